// File: rtl/prog_run_ctrl_if.sv
// Program-load and instruction-memory write bundle for prog_run_ctrl.
// Combinational path: none; this is a wiring bundle only.
// Backpressure: load_ready gates load_valid; the imem write port is fire-and-forget.
//
// Ports (signals):
//   load_valid/load_data/load_last : program word stream from the host
//   load_ready                     : controller accepts a word this cycle
//   imem_we/imem_waddr/imem_wdata  : instruction-memory write port
// master = the controller (sinks the load stream, drives the imem write port)
// slave  = host + memory side
interface prog_run_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              load_valid;
   logic [31:0]       load_data;
   logic              load_last;
   logic              load_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;

   modport master (
      input  load_valid, load_data, load_last,
      output load_ready, imem_we, imem_waddr, imem_wdata
   );

   modport slave (
      output load_valid, load_data, load_last,
      input  load_ready, imem_we, imem_waddr, imem_wdata
   );
endinterface

// File: rtl/prog_run_ctrl.sv
// Sequencer around the RV32I core: load program, hold core reset, run, detect halt.
// Latency: accepted word is written to imem one cycle later; busy/done/core_rst are registered.
// Backpressure: load_ready is high only in LOAD; words offered elsewhere are left pending.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle pulse, honoured in IDLE or HALT
//   bus (master)        : load stream in, imem write port out
//   core_rst/core_instr : processor reset out, currently fetched instruction in
//   busy/done/status    : LOAD|RSTC|RUN, HALT, halt cause (01 ecall, 10 self-jump, 11 timeout)
//   load_err/load_words : program overflowed memory, words written
//   cycle_count         : RUN cycles elapsed (saturating)
module prog_run_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int RST_CYCLES = 2,
   parameter int MAX_CYCLES = 1024,
   parameter int CNT_W      = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   prog_run_ctrl_if.master    bus,
   output logic               core_rst,
   input  logic [31:0]        core_instr,
   output logic               busy,
   output logic               done,
   output logic [1:0]         status,
   output logic               load_err,
   output logic [ADDR_W:0]    load_words,
   output logic [CNT_W-1:0]   cycle_count
);

   localparam logic [31:0] INSTR_ECALL    = 32'h0000_0073;
   localparam logic [31:0] INSTR_SELF_JMP = 32'h0000_006F; // jal x0,0
   localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int RUN_W = $clog2(MAX_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RSTC,
      S_RUN,
      S_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_cnt;
   logic [RC_W-1:0]   rst_cnt;
   // Timeout uses its own counter so a narrow, saturating cycle_count
   // cannot mask the budget.
   logic [RUN_W-1:0]  run_cnt;
   logic              accept;
   logic              clear_cnt;
   logic              set_err;
   logic [1:0]        halt_code;

   assign bus.load_ready = (state_q == S_LOAD);

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      clear_cnt = 1'b0;
      set_err   = 1'b0;
      halt_code = 2'b00;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d   = S_LOAD;
               clear_cnt = 1'b1;
            end
         end
         S_LOAD: begin
            if (bus.load_valid) begin
               accept = 1'b1;
               if (bus.load_last) begin
                  state_d = S_RSTC;
               end else if (&addr_cnt) begin
                  // Last free word taken without load_last: abort rather than wrap.
                  state_d = S_IDLE;
                  set_err = 1'b1;
               end
            end
         end
         S_RSTC: begin
            if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (core_instr == INSTR_ECALL) begin
               halt_code = 2'b01;
            end else if (core_instr == INSTR_SELF_JMP) begin
               halt_code = 2'b10;
            end else if (run_cnt == RUN_W'(MAX_CYCLES - 1)) begin
               halt_code = 2'b11;
            end
            if (halt_code != 2'b00) begin
               state_d = S_HALT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register plus outputs decoded from the next state, so they are
   // glitch-free and line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         core_rst <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         core_rst <= (state_d != S_RUN);
         busy     <= (state_d == S_LOAD) || (state_d == S_RSTC) || (state_d == S_RUN);
         done     <= (state_d == S_HALT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_cnt       <= '0;
         rst_cnt        <= '0;
         run_cnt        <= '0;
         bus.imem_we    <= 1'b0;
         bus.imem_waddr <= '0;
         bus.imem_wdata <= '0;
         load_words     <= '0;
         load_err       <= 1'b0;
         status         <= 2'b00;
         cycle_count    <= '0;
      end else begin
         bus.imem_we <= accept;
         rst_cnt     <= (state_q == S_RSTC) ? rst_cnt + RC_W'(1)  : '0;
         run_cnt     <= (state_q == S_RUN)  ? run_cnt + RUN_W'(1) : '0;
         if (accept) begin
            bus.imem_waddr <= addr_cnt;
            bus.imem_wdata <= bus.load_data;
            addr_cnt       <= addr_cnt + ADDR_W'(1);
            load_words     <= load_words + (ADDR_W+1)'(1);
         end
         if (clear_cnt) begin
            addr_cnt    <= '0;
            load_words  <= '0;
            load_err    <= 1'b0;
            status      <= 2'b00;
            cycle_count <= '0;
         end else if (state_q == S_RUN && !(&cycle_count)) begin
            cycle_count <= cycle_count + CNT_W'(1);
         end
         if (set_err) begin
            load_err <= 1'b1;
         end
         if (halt_code != 2'b00) begin
            status <= halt_code;
         end
      end
   end

endmodule
